// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: snoops the core register-file write port and
// queues committed writes (pc, rd, wdata) for a debug reader.
//
// Ports:
//   Clk, Reset          clock, async active-high reset
//   pc, reg_wr, rd,     core writeback snoop
//   wdata
//   trig_pc             PC that starts capture while ARMED
//   arm, stop           control pulses (arm has priority)
//   rd_ready            reader pops head entry
//   rd_valid, rd_data   show-ahead head entry
//   count               entries held (0..DEPTH)
//   overflow            sticky lost-entry flag (WRAP=1 only)
//   state               00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
//
// Optional: define TRACE_TIMESTAMP_EN to prepend a 16-bit cycle stamp
// to each entry (TW = 85 instead of 69).
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0,
  localparam int AW   = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  localparam int TW   = 85
`else
  localparam int TW   = 69
`endif
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [31:0]   pc,
  input  logic          reg_wr,
  input  logic [4:0]    rd,
  input  logic [31:0]   wdata,
  input  logic [31:0]   trig_pc,
  input  logic          arm,
  input  logic          stop,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [TW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_CAPT  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [AW:0] CFULL = (AW+1)'(DEPTH);

  state_t        st, st_nx;
  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [TW-1:0] entry;
  logic          trig_hit, push, pop;
  logic          full, ovw, wr_en;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;

  // The arm cycle itself is stamp 0, so the
  // counter resumes at 1 on the following cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)    ts <= '0;
    else if (arm) ts <= 16'd1;
    else          ts <= ts + 16'd1;
  end

  assign entry = {ts, pc, rd, wdata};
`else
  assign entry = {pc, rd, wdata};
`endif

  always_comb begin
    trig_hit = (st == S_ARMED) && (pc == trig_pc);
    push     = ((st == S_CAPT) || trig_hit)
             && reg_wr && (rd != 5'd0) && !arm;
    pop      = rd_valid && rd_ready;
    full     = (cnt == CFULL);
    // Full with no pop: circular mode drops the
    // oldest entry; stop mode never gets here.
    ovw      = WRAP && push && full && !pop;
    wr_en    = push && (!full || pop || WRAP);
  end

  always_comb begin
    st_nx = st;
    if (arm) begin
      st_nx = S_ARMED;
    end else begin
      unique case (st)
        S_IDLE:  st_nx = S_IDLE;
        S_ARMED: begin
          if (stop)          st_nx = S_DONE;
          else if (trig_hit) st_nx = S_CAPT;
        end
        S_CAPT: begin
          if (stop)
            st_nx = S_DONE;
          else if (!WRAP && push && !pop
                   && cnt == CFULL - 1'b1)
            st_nx = S_DONE;
        end
        S_DONE:  st_nx = S_DONE;
        default: st_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      st <= st_nx;
      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop || ovw)
          rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && !pop && !full)
          cnt <= cnt + 1'b1;
        else if (pop && !wr_en)
          cnt <= cnt - 1'b1;
        if (ovw)
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[wr_ptr] <= entry;
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign count    = cnt;
  assign state    = st;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: one DEPTH=4 stop-on-full instance
// and one DEPTH=4 circular instance share the snoop/control inputs.
module tb_wb_trace_buffer;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TW = 85;
`else
  localparam int TW = 69;
`endif

  logic          Clk, Reset;
  logic [31:0]   pc, wdata, trig_pc;
  logic          reg_wr, arm, stop;
  logic [4:0]    rd;
  logic          rr0, rr1;
  logic          v0, v1, o0, o1;
  logic [TW-1:0] d0, d1;
  logic [2:0]    c0, c1;
  logic [1:0]    s0, s1;

  int nvec = 0;
  int nerr = 0;

  wb_trace_buffer #(.DEPTH(4), .WRAP(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .pc(pc), .reg_wr(reg_wr),
    .rd(rd), .wdata(wdata), .trig_pc(trig_pc), .arm(arm),
    .stop(stop), .rd_ready(rr0), .rd_valid(v0),
    .rd_data(d0), .count(c0), .overflow(o0), .state(s0)
  );

  wb_trace_buffer #(.DEPTH(4), .WRAP(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .pc(pc), .reg_wr(reg_wr),
    .rd(rd), .wdata(wdata), .trig_pc(trig_pc), .arm(arm),
    .stop(stop), .rd_ready(rr1), .rd_valid(v1),
    .rd_data(d1), .count(c1), .overflow(o1), .state(s1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nvec++;
    if (s0 !== 2'b00 || c0 !== 3'd0 || v0 !== 1'b0
        || o0 !== 1'b0 || d0 !== '0) begin
      $display("FAIL reset: st=%b cnt=%0d v=%b ovf=%b data=%h",
               s0, c0, v0, o0, d0);
      nerr++;
    end
    step();
    Reset = 1'b0;
    step();
    nvec++;
    if (s1 !== 2'b00 || c1 !== 3'd0) begin
      $display("FAIL reset_idle: st=%b cnt=%0d want 00/0", s1, c1);
      nerr++;
    end
  endtask

  task automatic test_reset_mid();
    do_arm();
    nvec++;
    if (s0 !== 2'b01) begin
      $display("FAIL arm_state: got %b want 01", s0);
      nerr++;
    end
    trig_pc = 32'h100; pc = 32'h100;
    reg_wr = 1'b1; rd = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      wdata = i;
      step();
    end
    reg_wr = 1'b0;
    nvec++;
    if (c0 !== 3'd3 || s0 !== 2'b10) begin
      $display("FAIL mid_pre: cnt=%0d st=%b want 3/10", c0, s0);
      nerr++;
    end
    #2 Reset = 1'b1;
    #1;
    nvec++;
    if (s0 !== 2'b00 || c0 !== 3'd0 || v0 !== 1'b0 || o0 !== 1'b0) begin
      $display("FAIL async_reset: st=%b cnt=%0d v=%b ovf=%b want 00/0/0/0",
               s0, c0, v0, o0);
      nerr++;
    end
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_trigger();
    pc = 32'h0;
    do_arm();
    trig_pc = 32'h8;
    reg_wr = 1'b1;
    pc = 32'h4; rd = 5'd1; wdata = 32'hAA;
    step();
    nvec++;
    if (c0 !== 3'd0 || s0 !== 2'b01) begin
      $display("FAIL pre_trig: cnt=%0d st=%b want 0/01", c0, s0);
      nerr++;
    end
    pc = 32'h8; rd = 5'd2; wdata = 32'h1234;
    step();
    pc = 32'hC; rd = 5'd0; wdata = 32'h5;
    step();
    reg_wr = 1'b0;
    nvec++;
    if (c0 !== 3'd1 || s0 !== 2'b10 || v0 !== 1'b1) begin
      $display("FAIL trig: cnt=%0d st=%b v=%b want 1/10/1", c0, s0, v0);
      nerr++;
    end
    nvec++;
    if (d0[68:0] !== {32'h8, 5'd2, 32'h1234}) begin
      $display("FAIL trig_data: got %h want %h", d0[68:0],
               {32'h8, 5'd2, 32'h1234});
      nerr++;
    end
    rr0 = 1'b1;
    step();
    rr0 = 1'b0;
    nvec++;
    if (c0 !== 3'd0 || v0 !== 1'b0) begin
      $display("FAIL trig_drain: cnt=%0d v=%b want 0/0", c0, v0);
      nerr++;
    end
  endtask

  task automatic test_full_stop();
    do_arm();
    trig_pc = 32'h20; pc = 32'h20;
    reg_wr = 1'b1; rd = 5'd3;
    for (int i = 1; i <= 5; i++) begin
      wdata = i;
      step();
    end
    reg_wr = 1'b0;
    nvec++;
    if (c0 !== 3'd4 || s0 !== 2'b11 || o0 !== 1'b0) begin
      $display("FAIL full_stop: cnt=%0d st=%b ovf=%b want 4/11/0",
               c0, s0, o0);
      nerr++;
    end
    for (int j = 1; j <= 4; j++) begin
      nvec++;
      if (v0 !== 1'b1 || d0[31:0] !== 32'(j)) begin
        $display("FAIL full_drain%0d: v=%b data=%0d want 1/%0d",
                 j, v0, d0[31:0], j);
        nerr++;
      end
      rr0 = 1'b1;
      step();
    end
    rr0 = 1'b0;
    nvec++;
    if (c0 !== 3'd0 || v0 !== 1'b0 || s0 !== 2'b11) begin
      $display("FAIL full_empty: cnt=%0d v=%b st=%b want 0/0/11",
               c0, v0, s0);
      nerr++;
    end
    rr0 = 1'b1;
    step();
    rr0 = 1'b0;
    nvec++;
    if (c0 !== 3'd0) begin
      $display("FAIL empty_pop: cnt=%0d want 0", c0);
      nerr++;
    end
  endtask

  task automatic test_wrap();
    do_arm();
    trig_pc = 32'h40; pc = 32'h40;
    reg_wr = 1'b1; rd = 5'd3;
    for (int i = 1; i <= 6; i++) begin
      wdata = i;
      step();
    end
    reg_wr = 1'b0;
    nvec++;
    if (c1 !== 3'd4 || o1 !== 1'b1 || s1 !== 2'b10) begin
      $display("FAIL wrap: cnt=%0d ovf=%b st=%b want 4/1/10",
               c1, o1, s1);
      nerr++;
    end
    for (int j = 3; j <= 6; j++) begin
      nvec++;
      if (v1 !== 1'b1 || d1[31:0] !== 32'(j)) begin
        $display("FAIL wrap_drain%0d: v=%b data=%0d want 1/%0d",
                 j, v1, d1[31:0], j);
        nerr++;
      end
      rr1 = 1'b1;
      step();
    end
    rr1 = 1'b0;
    nvec++;
    if (c1 !== 3'd0) begin
      $display("FAIL wrap_empty: cnt=%0d want 0", c1);
      nerr++;
    end
  endtask

  task automatic test_back_to_back();
    do_arm();
    trig_pc = 32'h60; pc = 32'h60;
    reg_wr = 1'b1; rd = 5'd4;
    for (int i = 11; i <= 14; i++) begin
      wdata = i;
      step();
    end
    nvec++;
    if (c1 !== 3'd4 || o1 !== 1'b0 || d1[31:0] !== 32'd11) begin
      $display("FAIL b2b_pre: cnt=%0d ovf=%b head=%0d want 4/0/11",
               c1, o1, d1[31:0]);
      nerr++;
    end
    wdata = 32'd15; rr1 = 1'b1;
    step();
    rr1 = 1'b0; reg_wr = 1'b0;
    nvec++;
    if (c1 !== 3'd4 || o1 !== 1'b0 || d1[31:0] !== 32'd12) begin
      $display("FAIL b2b: cnt=%0d ovf=%b head=%0d want 4/0/12",
               c1, o1, d1[31:0]);
      nerr++;
    end
  endtask

  task automatic test_stop();
    do_arm();
    trig_pc = 32'h80; pc = 32'h80;
    reg_wr = 1'b1; rd = 5'd5; wdata = 32'd1;
    step();
    wdata = 32'd2; stop = 1'b1;
    step();
    stop = 1'b0; wdata = 32'd3;
    step();
    reg_wr = 1'b0;
    nvec++;
    if (s0 !== 2'b11 || c0 !== 3'd2) begin
      $display("FAIL stop: st=%b cnt=%0d want 11/2", s0, c0);
      nerr++;
    end
  endtask

  task automatic test_arm_priority();
    do_arm();
    trig_pc = 32'hA0; pc = 32'hA0;
    reg_wr = 1'b1; rd = 5'd6;
    wdata = 32'd1; step();
    wdata = 32'd2; step();
    nvec++;
    if (s0 !== 2'b10 || c0 !== 3'd2) begin
      $display("FAIL prio_pre: st=%b cnt=%0d want 10/2", s0, c0);
      nerr++;
    end
    arm = 1'b1; stop = 1'b1; wdata = 32'd3;
    step();
    arm = 1'b0; stop = 1'b0; reg_wr = 1'b0;
    nvec++;
    if (s0 !== 2'b01 || c0 !== 3'd0 || v0 !== 1'b0) begin
      $display("FAIL arm_prio: st=%b cnt=%0d v=%b want 01/0/0",
               s0, c0, v0);
      nerr++;
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    pc = 32'h0; trig_pc = 32'hC0;
    do_arm();
    for (int i = 0; i < 4; i++) step();
    pc = 32'hC0; reg_wr = 1'b1; rd = 5'd7; wdata = 32'h77;
    step();
    reg_wr = 1'b0;
    nvec++;
    if (d0[84:69] !== 16'd5 || c0 !== 3'd1) begin
      $display("FAIL stamp: got %0d cnt=%0d want 5/1", d0[84:69], c0);
      nerr++;
    end
  endtask
`endif

  initial begin
    Reset = 1'b1;
    pc = '0; wdata = '0; trig_pc = 32'hFFFF_FFFF;
    reg_wr = 1'b0; rd = '0;
    arm = 1'b0; stop = 1'b0;
    rr0 = 1'b0; rr1 = 1'b0;
    test_reset();
    test_reset_mid();
    test_trigger();
    test_full_stop();
    test_wrap();
    test_back_to_back();
    test_stop();
    test_arm_priority();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
